// File: rtl/ahb_subordinate_mem_if.sv
// ---------------------------------------------------------------------------
// ahb_sub_pkg / ahb_subordinate_mem_if
//
// Purpose : AHB encodings shared by the subordinate memory and its benches,
//           plus the bus interface that carries the address/data-phase
//           signals between a manager and ahb_subordinate_mem.
//
// Interface signals (names follow the subordinate's view of the bus):
//   i_hsel, i_haddr, i_htrans, i_hwrite, i_hsize, i_hburst, i_hwdata,
//   i_hready, i_err_inject, i_retry_inject     : manager -> subordinate
//   o_hreadyout, o_hrdata, o_hresp, o_xfer_cnt : subordinate -> manager
//
// Modports: master (drives the i_* side), slave (drives the o_* side).
// ---------------------------------------------------------------------------
package ahb_sub_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } t_htrans;

  typedef enum logic [2:0] {
    HSIZE_8    = 3'd0,
    HSIZE_16   = 3'd1,
    HSIZE_32   = 3'd2,
    HSIZE_64   = 3'd3,
    HSIZE_128  = 3'd4,
    HSIZE_256  = 3'd5,
    HSIZE_512  = 3'd6,
    HSIZE_1024 = 3'd7
  } t_hsize;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } t_hburst;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } t_hresp;

endpackage

interface ahb_subordinate_mem_if #(
  parameter int DATA_WDT = 32
);
  import ahb_sub_pkg::*;

  logic                i_hsel;
  logic [31:0]         i_haddr;
  t_htrans             i_htrans;
  logic                i_hwrite;
  t_hsize              i_hsize;
  t_hburst             i_hburst;
  logic [DATA_WDT-1:0] i_hwdata;
  logic                i_hready;
  logic                i_err_inject;
  logic                i_retry_inject;
  logic                o_hreadyout;
  logic [DATA_WDT-1:0] o_hrdata;
  t_hresp              o_hresp;
  logic [15:0]         o_xfer_cnt;

  modport master (
    output i_hsel, i_haddr, i_htrans, i_hwrite, i_hsize, i_hburst, i_hwdata,
           i_hready, i_err_inject, i_retry_inject,
    input  o_hreadyout, o_hrdata, o_hresp, o_xfer_cnt
  );

  modport slave (
    input  i_hsel, i_haddr, i_htrans, i_hwrite, i_hsize, i_hburst, i_hwdata,
           i_hready, i_err_inject, i_retry_inject,
    output o_hreadyout, o_hrdata, o_hresp, o_xfer_cnt
  );

endinterface

// File: rtl/ahb_subordinate_mem.sv
// ---------------------------------------------------------------------------
// ahb_subordinate_mem
//
// Purpose : Parametrised AHB subordinate RAM with HSIZE-aware byte-lane
//           writes, size/alignment/range checking, directed ERROR/RETRY
//           injection, two-cycle fault responses and programmable waits.
//
// Ports   : i_hclk      - clock, everything on the rising edge
//           i_hreset_n  - synchronous active-low reset
//           bus         - ahb_subordinate_mem_if.slave (address/data phase
//                         inputs, hreadyout/hrdata/hresp/xfer_cnt outputs)
//
// Build option: define AHB_SUB_MEM_LFSR_WAIT_EN to draw each transfer's wait
//           count from a 16-bit Galois LFSR, clamped to WAIT_CYCLES. Left
//           undefined, every transfer inserts exactly WAIT_CYCLES waits.
// ---------------------------------------------------------------------------
module ahb_subordinate_mem
  import ahb_sub_pkg::*;
#(
  parameter int          DATA_WDT    = 32,
  parameter int          MEM_DEPTH   = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input logic                  i_hclk,
  input logic                  i_hreset_n,
  ahb_subordinate_mem_if.slave bus
);

  localparam int          NBYTES    = DATA_WDT / 8;
  localparam int          LANE_W    = $clog2(NBYTES);
  localparam int          WORD_AW   = $clog2(MEM_DEPTH);
  localparam logic [32:0] MEM_BYTES = 33'(MEM_DEPTH * NBYTES);
  localparam logic [2:0]  MAX_SIZE  = 3'(LANE_W);
  localparam logic [3:0]  WAIT_MAX  = 4'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    ST_READY,
    ST_WAIT,
    ST_DATA,
    ST_RESP1,
    ST_RESP2
  } t_state;

  t_state               state_q;
  logic [3:0]           wait_q;
  t_hresp               fault_q;
  logic                 write_q;
  logic [2:0]           size_q;
  logic [LANE_W-1:0]    lane_q;
  logic [WORD_AW-1:0]   word_q;
  logic                 ready_q;
  t_hresp               resp_q;
  logic [15:0]          cnt_q;
  logic [DATA_WDT-1:0]  mem [MEM_DEPTH];

  // ---------------- address-phase decode ----------------
  logic        accept;
  logic [32:0] offs;
  logic [7:0]  align_mask;
  t_hresp      fault_nxt;
  logic [3:0]  wait_load;
  logic [NBYTES-1:0] be;

  // Only a ready subordinate samples the address phase, so a stalled bus
  // cannot sneak a second transfer in during waits or RESP1.
  assign accept = ready_q && bus.i_hsel && bus.i_hready &&
                  (bus.i_htrans == HTRANS_NONSEQ || bus.i_htrans == HTRANS_SEQ);

  // Offset below the base wraps to a huge 33-bit value, so one compare
  // covers both ends of the window.
  assign offs       = {1'b0, bus.i_haddr} - {1'b0, BASE_ADDR};
  assign align_mask = (8'd1 << bus.i_hsize) - 8'd1;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    fault_nxt = HRESP_OKAY;
    if (bus.i_hsize > MAX_SIZE)                  fault_nxt = HRESP_ERROR;
    else if (|(bus.i_haddr[7:0] & align_mask))   fault_nxt = HRESP_ERROR;
    else if (offs >= MEM_BYTES)                  fault_nxt = HRESP_ERROR;
    else if (bus.i_err_inject)                   fault_nxt = HRESP_ERROR;
    else if (bus.i_retry_inject)                 fault_nxt = HRESP_RETRY;
  end

`ifdef AHB_SUB_MEM_LFSR_WAIT_EN
  logic [15:0] lfsr_q;

  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
  always_ff @(posedge i_hclk) begin
    if (!i_hreset_n) lfsr_q <= LFSR_SEED;
    else             lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  assign wait_load = (lfsr_q[3:0] < WAIT_MAX) ? lfsr_q[3:0] : WAIT_MAX;
`else
  assign wait_load = WAIT_MAX;
`endif

  // ---------------- transfer FSM ----------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_hclk) begin
    if (!i_hreset_n) begin
      state_q <= ST_READY;
      wait_q  <= '0;
      fault_q <= HRESP_OKAY;
      write_q <= 1'b0;
      size_q  <= '0;
      lane_q  <= '0;
      word_q  <= '0;
      ready_q <= 1'b1;
      resp_q  <= HRESP_OKAY;
      cnt_q   <= '0;
    end else begin
      if (state_q == ST_DATA) cnt_q <= cnt_q + 16'd1;

      if (accept) begin
        fault_q <= fault_nxt;
        write_q <= bus.i_hwrite;
        size_q  <= bus.i_hsize;
        lane_q  <= bus.i_haddr[LANE_W-1:0];
        word_q  <= offs[LANE_W +: WORD_AW];
        wait_q  <= wait_load;
        if (wait_load != 4'd0) begin
          state_q <= ST_WAIT;
          ready_q <= 1'b0;
          resp_q  <= HRESP_OKAY;
        end else if (fault_nxt != HRESP_OKAY) begin
          state_q <= ST_RESP1;
          ready_q <= 1'b0;
          resp_q  <= fault_nxt;
        end else begin
          state_q <= ST_DATA;
          ready_q <= 1'b1;
          resp_q  <= HRESP_OKAY;
        end
      end else begin
        unique case (state_q)
          ST_WAIT: begin
            if (wait_q == 4'd1) begin
              if (fault_q != HRESP_OKAY) begin
                state_q <= ST_RESP1;
                ready_q <= 1'b0;
                resp_q  <= fault_q;
              end else begin
                state_q <= ST_DATA;
                ready_q <= 1'b1;
                resp_q  <= HRESP_OKAY;
              end
            end else begin
              wait_q <= wait_q - 4'd1;
            end
          end
          ST_RESP1: begin
            state_q <= ST_RESP2;
            ready_q <= 1'b1;
          end
          default: begin
            state_q <= ST_READY;
            ready_q <= 1'b1;
            resp_q  <= HRESP_OKAY;
          end
        endcase
      end
    end
  end

  // ---------------- memory ----------------
  always_comb begin
    be = '0;
    for (int b = 0; b < NBYTES; b++)
      be[b] = (b >= int'(lane_q)) && (b < int'(lane_q) + (1 << int'(size_q)));
  end

  // NOTE: the array has no reset; contents survive reset. The reset term only
  // gates the enable so a write pending at a reset edge is dropped.
  always_ff @(posedge i_hclk) begin
    if (i_hreset_n && state_q == ST_DATA && write_q) begin
      for (int b = 0; b < NBYTES; b++)
        if (be[b]) mem[word_q][8*b +: 8] <= bus.i_hwdata[8*b +: 8];
    end
  end

  assign bus.o_hreadyout = ready_q;
  assign bus.o_hresp     = resp_q;
  assign bus.o_xfer_cnt  = cnt_q;
  assign bus.o_hrdata    = (state_q == ST_DATA && !write_q) ? mem[word_q] : '0;

endmodule

// File: tb/tb_ahb_subordinate_mem.sv
module tb_ahb_subordinate_mem;
  import ahb_sub_pkg::*;

  localparam logic [31:0] B0    = 32'h0000_4000;  // zero-wait instance
  localparam logic [31:0] B1    = 32'h0000_1000;  // three-wait instance
  localparam int          DEPTH = 256;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // shared manager-side drive, decoded onto two subordinates by dut_sel
  int      dut_sel;
  logic    hsel, hwrite, err_inj, retry_inj;
  logic [31:0] haddr, hwdata;
  t_htrans htrans;
  t_hsize  hsize;
  t_hburst hburst;

  ahb_subordinate_mem_if #(.DATA_WDT(32)) bus0 ();
  ahb_subordinate_mem_if #(.DATA_WDT(32)) bus1 ();

  logic        bus_hready;
  t_hresp      bus_hresp;
  logic [31:0] bus_hrdata;
  assign bus_hready = (dut_sel == 1) ? bus1.o_hreadyout : bus0.o_hreadyout;
  assign bus_hresp  = (dut_sel == 1) ? bus1.o_hresp     : bus0.o_hresp;
  assign bus_hrdata = (dut_sel == 1) ? bus1.o_hrdata    : bus0.o_hrdata;

  assign bus0.i_hsel = hsel && (dut_sel == 0);
  assign bus1.i_hsel = hsel && (dut_sel == 1);
  assign bus0.i_haddr = haddr;          assign bus1.i_haddr = haddr;
  assign bus0.i_htrans = htrans;        assign bus1.i_htrans = htrans;
  assign bus0.i_hwrite = hwrite;        assign bus1.i_hwrite = hwrite;
  assign bus0.i_hsize = hsize;          assign bus1.i_hsize = hsize;
  assign bus0.i_hburst = hburst;        assign bus1.i_hburst = hburst;
  assign bus0.i_hwdata = hwdata;        assign bus1.i_hwdata = hwdata;
  assign bus0.i_hready = bus_hready;    assign bus1.i_hready = bus_hready;
  assign bus0.i_err_inject = err_inj;   assign bus1.i_err_inject = err_inj;
  assign bus0.i_retry_inject = retry_inj; assign bus1.i_retry_inject = retry_inj;

  ahb_subordinate_mem #(.DATA_WDT(32), .MEM_DEPTH(DEPTH), .BASE_ADDR(B0),
                        .WAIT_CYCLES(0), .LFSR_SEED(16'hACE1))
    u_dut0 (.i_hclk(clk), .i_hreset_n(rst_n), .bus(bus0.slave));

  ahb_subordinate_mem #(.DATA_WDT(32), .MEM_DEPTH(DEPTH), .BASE_ADDR(B1),
                        .WAIT_CYCLES(3), .LFSR_SEED(16'hACE1))
    u_dut1 (.i_hclk(clk), .i_hreset_n(rst_n), .bus(bus1.slave));

  // ---------------- scoreboard and reference model ----------------
  typedef struct packed {
    t_hresp      resp;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] shadow [2][DEPTH];
  int          cnt_model [2];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] base_of();
    return (dut_sel == 1) ? B1 : B0;
  endfunction

  function automatic int nom_wait();
    return (dut_sel == 1) ? 3 : 0;
  endfunction

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr - base_of()) >> 2) % DEPTH;
  endfunction

  function automatic t_hresp predict(input logic [31:0] addr, input t_hsize sz,
                                     input logic ei, input logic ri);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, base_of()};
    if (sz > HSIZE_32)                            return HRESP_ERROR;
    if ((addr & ((32'd1 << sz) - 32'd1)) != 0)    return HRESP_ERROR;
    if (off >= 33'(DEPTH * 4))                    return HRESP_ERROR;
    if (ei)                                       return HRESP_ERROR;
    if (ri)                                       return HRESP_RETRY;
    return HRESP_OKAY;
  endfunction

  task automatic expect_push(input logic wr, input logic [31:0] addr, input t_hsize sz,
                             input logic [31:0] wdata, input logic ei, input logic ri);
    exp_t e;
    int   w, lane;
    e.resp = predict(addr, sz, ei, ri);
    e.data = '0;
    if (e.resp == HRESP_OKAY) begin
      w = word_of(addr);
      if (wr) begin
        lane = int'(addr[1:0]);
        for (int b = lane; b < lane + (1 << int'(sz)); b++)
          shadow[dut_sel][w][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        e.data = shadow[dut_sel][w];
      end
    end
    sb.push_back(e);
  endtask

  // Counts low-hreadyout cycles until the data phase reaches its last cycle.
  task automatic wait_ready(input string tag, output int lows, output t_hresp r1);
    bit done;
    lows = 0;
    r1   = HRESP_OKAY;
    done = 1'b0;
    for (int i = 0; i < 41 && !done; i++) begin
      @(negedge clk);
      if (bus_hready) done = 1'b1;
      else begin
        r1 = bus_hresp;
        lows++;
      end
    end
    if (!done) check({tag, "_ready_timeout"}, done, 1'b1);
  endtask

  task automatic complete(input string tag, input int lows, input t_hresp r1);
    exp_t e;
    int   extra;
    check({tag, "_sb_nonempty"}, sb.size() != 0, 1'b1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    extra = (e.resp != HRESP_OKAY) ? 1 : 0;
    check({tag, "_resp"}, bus_hresp, e.resp);
    check({tag, "_rdata"}, bus_hrdata, e.data);
    if (e.resp != HRESP_OKAY) check({tag, "_resp1"}, r1, e.resp);
`ifdef AHB_SUB_MEM_LFSR_WAIT_EN
    check({tag, "_waits"}, (lows >= extra) && (lows <= nom_wait() + extra), 1'b1);
`else
    check({tag, "_waits"}, lows, nom_wait() + extra);
`endif
    if (e.resp == HRESP_OKAY) cnt_model[dut_sel]++;
  endtask

  task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                      input t_hsize sz, input logic [31:0] wdata,
                      input logic ei = 1'b0, input logic ri = 1'b0);
    int     lows;
    t_hresp r1;
    expect_push(wr, addr, sz, wdata, ei, ri);
    @(posedge clk); #1;
    hsel = 1'b1; haddr = addr; htrans = HTRANS_NONSEQ; hwrite = wr;
    hsize = sz; hburst = HBURST_SINGLE; err_inj = ei; retry_inj = ri;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = HTRANS_IDLE; err_inj = 1'b0; retry_inj = 1'b0;
    hwdata = wdata;
    wait_ready(tag, lows, r1);
    complete(tag, lows, r1);
  endtask

  // Pipelined INCR4 word read: each beat's address phase overlaps the
  // previous beat's final data cycle.
  task automatic burst_read4(input logic [31:0] addr);
    int     lows;
    t_hresp r1;
    expect_push(1'b0, addr, HSIZE_32, '0, 1'b0, 1'b0);
    @(posedge clk); #1;
    hsel = 1'b1; haddr = addr; htrans = HTRANS_NONSEQ; hwrite = 1'b0;
    hsize = HSIZE_32; hburst = HBURST_INCR4;
    for (int k = 0; k < 5; k++) begin
      wait_ready("burst", lows, r1);
      if (k > 0) complete("burst", lows, r1);
      @(posedge clk); #1;
      if (k < 3) begin
        expect_push(1'b0, addr + 32'(4 * (k + 1)), HSIZE_32, '0, 1'b0, 1'b0);
        haddr = addr + 32'(4 * (k + 1)); htrans = HTRANS_SEQ;
      end else begin
        hsel = 1'b0; htrans = HTRANS_IDLE;
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rdy0"}, bus0.o_hreadyout, 1'b1);
    check({tag, "_resp0"}, bus0.o_hresp, HRESP_OKAY);
    check({tag, "_rdata0"}, bus0.o_hrdata, 32'h0);
    check({tag, "_cnt0"}, bus0.o_xfer_cnt, 16'h0);
    check({tag, "_rdy1"}, bus1.o_hreadyout, 1'b1);
    check({tag, "_resp1"}, bus1.o_hresp, HRESP_OKAY);
    check({tag, "_rdata1"}, bus1.o_hrdata, 32'h0);
    check({tag, "_cnt1"}, bus1.o_xfer_cnt, 16'h0);
  endtask

  task automatic check_cnt(input string tag);
    @(posedge clk); #1;
    check({tag, "_cnt0"}, bus0.o_xfer_cnt, 16'(cnt_model[0]));
    check({tag, "_cnt1"}, bus1.o_xfer_cnt, 16'(cnt_model[1]));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int w, lane;
    t_hsize sz;
    rst_n = 1'b0; dut_sel = 0;
    hsel = 1'b0; haddr = '0; htrans = HTRANS_IDLE; hwrite = 1'b0;
    hsize = HSIZE_32; hburst = HBURST_SINGLE; hwdata = '0;
    err_inj = 1'b0; retry_inj = 1'b0;
    cnt_model[0] = 0; cnt_model[1] = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_idle("reset");

    // zero-wait word write/read
    dut_sel = 0;
    xfer("w_deadbeef", 1'b1, B0 + 32'h8, HSIZE_32, 32'hDEADBEEF);
    xfer("r_deadbeef", 1'b0, B0 + 32'h8, HSIZE_32, 32'h0);
    check_cnt("after_wr_rd");

    // byte-lane write over a known word
    xfer("w_base", 1'b1, B0 + 32'h8, HSIZE_32, 32'h11223344);
    xfer("w_byte", 1'b1, B0 + 32'h9, HSIZE_8,  32'h00005A00);
    xfer("r_byte", 1'b0, B0 + 32'h8, HSIZE_32, 32'h0);
    check({"byte_model"}, shadow[0][2], 32'h11225A44);
    xfer("w_half", 1'b1, B0 + 32'hA, HSIZE_16, 32'hBEEF0000);
    xfer("r_half", 1'b0, B0 + 32'h8, HSIZE_32, 32'h0);

    // faults: out of range, misaligned, too wide, injected
    xfer("w_zero", 1'b1, B0, HSIZE_32, 32'h01020304);
    check_cnt("before_faults");
    xfer("r_oor",   1'b0, B0 + 32'(DEPTH * 4), HSIZE_32, 32'h0);
    xfer("r_below", 1'b0, B0 - 32'h4,          HSIZE_32, 32'h0);
    xfer("w_misal", 1'b1, B0 + 32'h2,          HSIZE_32, 32'hFFFFFFFF);
    xfer("w_wide",  1'b1, B0,                  HSIZE_64, 32'hFFFFFFFF);
    xfer("w_einj",  1'b1, B0,                  HSIZE_32, 32'hFFFFFFFF, 1'b1, 1'b0);
    check_cnt("after_faults");
    xfer("r_after_faults", 1'b0, B0, HSIZE_32, 32'h0);
    xfer("w_retry", 1'b1, B0, HSIZE_32, 32'hCAFEF00D, 1'b0, 1'b1);
    xfer("r_after_retry", 1'b0, B0, HSIZE_32, 32'h0);
    xfer("w_reissue", 1'b1, B0, HSIZE_32, 32'hCAFEF00D);
    xfer("r_reissue", 1'b0, B0, HSIZE_32, 32'h0);
    xfer("idle_gap", 1'b0, B0 + 32'h8, HSIZE_32, 32'h0);
    check_cnt("end_dut0");

    // three-wait instance: burst, faults with waits
    dut_sel = 1;
    for (int i = 0; i < 16; i++)
      xfer("init", 1'b1, B1 + 32'(4 * i), HSIZE_32, 32'hA5000000 | 32'(i * 32'h01010101));
    check_cnt("after_init");
    burst_read4(B1 + 32'h10);
    check_cnt("after_burst");
    xfer("r_oor_wait", 1'b0, B1 + 32'(DEPTH * 4), HSIZE_32, 32'h0);
    xfer("w_retry_wait", 1'b1, B1, HSIZE_32, 32'h0BADF00D, 1'b0, 1'b1);
    xfer("r_retry_wait", 1'b0, B1, HSIZE_32, 32'h0);

    // reset in the middle of a write drops it
    xfer("rst_pre", 1'b1, B1 + 32'h20, HSIZE_32, 32'hAAAA5555);
    @(posedge clk); #1;
    hsel = 1'b1; haddr = B1 + 32'h20; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_32;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'hBAD0BAD0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cnt_model[0] = 0; cnt_model[1] = 0;
    @(negedge clk);
    check_idle("mid_reset");
    xfer("r_after_reset", 1'b0, B1 + 32'h20, HSIZE_32, 32'h0);

    // random sized accesses over the initialised window
    for (int i = 0; i < 1000; i++) begin
      w    = $urandom_range(0, 15);
      sz   = t_hsize'($urandom_range(0, 2));
      lane = $urandom_range(0, 3) & ~((1 << int'(sz)) - 1);
      xfer("rnd", 1'($urandom_range(0, 1)), B1 + 32'(4 * w + lane), sz, $urandom);
    end
    check_cnt("end_random");
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_subordinate_mem.md
# ahb_subordinate_mem

Parametrised, synthesisable AHB subordinate memory. It is the next-generation replacement for the ad-hoc subordinate model used in the manager bench, with these additions:
- configurable data width, depth and base address;
- HSIZE-aware byte-lane writes;
- protocol-correct two-cycle ERROR/RETRY responses;
- address/alignment checking and directed fault injection;
- fixed or pseudo-random wait states.

It sits on the AHB bus opposite `ahb_manager` in unit and system benches, and can be used as a scratch RAM in FPGA builds.

## Interface
- `DATA_WDT`, 32 — HWDATA/HRDATA width; 32, 64 or 128.
- `MEM_DEPTH`, 256 — memory depth in DATA_WDT-wide words; power of two.
- `BASE_ADDR`, 32'h0 — byte address of word 0; aligned to MEM_DEPTH*DATA_WDT/8.
- `WAIT_CYCLES`, 0 — wait states per transfer (0..15); upper bound when random waits are enabled.
- `LFSR_SEED`, 16'hACE1 — non-zero LFSR seed.
- `i_hclk` input 1 — clock; all logic on its rising edge.
- `i_hreset_n` input 1 — reset, synchronous, active-low.
- `i_hsel` input 1 — subordinate select.
- `i_haddr` input 32 — byte address.
- `i_htrans` input t_htrans — IDLE/BUSY/NONSEQ/SEQ.
- `i_hwrite` input 1 — 1 = write.
- `i_hsize` input t_hsize — transfer size.
- `i_hburst` input t_hburst — informational only; every beat is checked independently.
- `i_hwdata` input DATA_WDT — write data, data phase.
- `i_hready` input 1 — bus HREADY (previous data phase complete).
- `i_err_inject` input 1 — force ERROR on the next accepted transfer.
- `i_retry_inject` input 1 — force RETRY on the next accepted transfer.
- `o_hreadyout` output 1 — subordinate ready.
- `o_hrdata` output DATA_WDT — read data.
- `o_hresp` output t_hresp — OKAY/ERROR/RETRY (SPLIT is never issued).
- `o_xfer_cnt` output 16 — count of OKAY-completed NONSEQ/SEQ transfers; wraps.

## Operation

**Address phase acceptance**
- Accept when `i_hsel & i_hready & i_htrans ∈ {NONSEQ, SEQ}`.
- Register address, write flag and size, and load the wait counter.
- IDLE or BUSY with `i_hsel & i_hready`: zero-wait OKAY, no side effects.

**Checks at acceptance, in priority order**
1. Size wider than DATA_WDT → ERROR.
2. Address not size-aligned → ERROR.
3. Address outside `[BASE_ADDR, BASE_ADDR + MEM_DEPTH*DATA_WDT/8)` → ERROR.
4. `i_err_inject` → ERROR.
5. `i_retry_inject` → RETRY.
- Injects are sampled only at acceptance.

**FSM**
- OKAY path: `READY → WAIT (while count ≠ 0, o_hreadyout = 0) → DATA (o_hreadyout = 1, o_hresp = OKAY) → READY`, or the next accept in the same cycle.
- Fault path: `WAIT → RESP1 (o_hreadyout = 0, o_hresp = ERR/RETRY) → RESP2 (o_hreadyout = 1, same o_hresp)`.
- WAIT is skipped when the wait count is 0; wait states precede the response cycles for the fault path too.
- A transfer accepted in RESP2 or DATA proceeds normally, giving back-to-back pipelining.

**Writes**
- Memory is updated on the completing edge of an OKAY data phase only.
- Byte lanes are set from size and `addr[log2(DATA_WDT/8)-1:0]`; other lanes are retained.
- Faulted transfers never modify memory.

**Reads**
- `o_hrdata = mem[registered word address]` while an OKAY read data phase is active, else 0.
- No lane masking; the manager selects lanes.

**Memory and counter**
- Memory contents are not reset.
- `o_xfer_cnt` increments on each OKAY completion and wraps 16'hFFFF → 0.

## Timing
- **Reset values:** `o_hreadyout = 1`, `o_hresp = OKAY`, `o_hrdata = 0`, `o_xfer_cnt = 0`, FSM = READY, LFSR = LFSR_SEED.
- Reset asserted mid-transfer aborts it at the next edge; a pending write is dropped.
- **Zero-wait latency:** accept at edge N; the data phase completes at edge N+1 with `o_hreadyout = 1` during cycle N..N+1.
- A read immediately following a write to the same address returns the new data, because the write commits at the edge that accepts the read.
- **Fault latency:** at least 2 cycles after the wait states.
- While `o_hreadyout = 0`, address-phase inputs are ignored.

## Configuration
- **`AHB_SUB_MEM_LFSR_WAIT_EN` defined:**
  - A 16-bit Galois LFSR (taps 16,14,13,11) advances every cycle.
  - Per-transfer wait count = `min(lfsr[3:0], WAIT_CYCLES)`, sampled at acceptance.
- **Undefined:**
  - Every transfer uses exactly WAIT_CYCLES wait states.
  - No LFSR logic is present.

## Test plan
- **Single word write/read, WAIT_CYCLES = 0:** write 32'hDEADBEEF to BASE_ADDR+8, then read it → OKAY, `o_hreadyout` never low, read data DEADBEEF, `o_xfer_cnt = 2`.
- **Byte write:** W8 write of 8'h5A to BASE_ADDR+9 over word 32'h11223344 → readback 32'h11225A44.
- **Out-of-range read:** read at `BASE_ADDR + MEM_DEPTH*4` → cycle 1 `{hreadyout 0, ERROR}`, cycle 2 `{1, ERROR}`; `o_hrdata = 0`; counter unchanged.
- **Misaligned W32 write:** write at BASE_ADDR+2 → ERROR sequence; memory unchanged.
- **Retry inject:** `i_retry_inject = 1` on a write to +0 → two-cycle RETRY and no write; re-issued write → OKAY and data stored.
- **WAIT_CYCLES = 3, macro undefined:** 4-beat INCR4 read → each beat has exactly 3 low `o_hreadyout` cycles; `o_xfer_cnt` +4.
- **Macro defined:** 1000 random accesses → every wait ≤ WAIT_CYCLES and all data matches the scoreboard.
